// File: rtl/fifo_rd_ctrl.sv
// Purpose : read-side pointer/flag controller of an async FIFO (Gray pointers, level, flags).
// Latency : rd_addr is presented from the read pointer register; rd_valid follows one cycle after an accepted read.
// Backpres: reads are refused while empty (underflow pulse, no pointer move); no stall input.
//
// Ports:
//   clk, rst_n      read-domain clock, asynchronous active-low reset
//   rd_en           consumer read request
//   wptr_gray_sync  write pointer (Gray), already synchronized into clk
//   rd_addr         memory read address (low bits of binary read pointer)
//   rptr_gray       registered Gray read pointer for the write domain
//   empty           registered empty flag
//   almost_empty    registered, occupancy <= ALMOST_EMPTY_TH
//   rd_valid        memory data for the previous accepted read is valid
//   underflow       one-cycle pulse after a read attempted while empty
//   level           registered occupancy seen from the read side
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  rd_valid,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   level
);

  // Pointers carry one extra wrap bit so full (level = depth) and empty
  // (level = 0) are distinguishable.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          rd_accept;
  logic          empty_next;
  logic          almost_empty_next;

  // Address comes straight from the register so the memory sees a clean,
  // glitch-free read address.
  assign rd_addr = rbin[ADDR_WIDTH-1:0];

  always_comb begin
    rd_accept  = rd_en & ~empty;
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, rd_accept};
    rgray_next = rbin_next ^ (rbin_next >> 1);

    // Gray -> binary: each binary bit is the XOR of all Gray bits at and
    // above its position.
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(wptr_gray_sync >> i);
    end

    // Modulo arithmetic on the wrap-extended pointers yields 0..depth.
    level_next = wbin - rbin_next;

    // The synchronized write pointer can only lag the real one, so this
    // comparison may report empty late but never falsely report data.
    empty_next        = (rgray_next == wptr_gray_sync);
    almost_empty_next = (level_next <= AE_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin         <= '0;
      rptr_gray    <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      level        <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr_gray    <= rgray_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
      level        <= level_next;
      rd_valid     <= rd_accept;
      underflow    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Purpose : self-checking bench for fifo_rd_ctrl with a behavioural FIFO memory and data scoreboard.
// Latency : outputs sampled 1 ns after each rising edge; read data checked at the following falling edge.
// Backpres: not applicable (bench drives rd_en and the write pointer directly).
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic [4:0] wptr_gray_sync;
  logic [3:0] rd_addr;
  logic [4:0] rptr_gray;
  logic       empty, almost_empty, rd_valid, underflow;
  logic [4:0] level;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .ALMOST_EMPTY_TH(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wptr_gray_sync(wptr_gray_sync),
    .rd_addr(rd_addr), .rptr_gray(rptr_gray), .empty(empty),
    .almost_empty(almost_empty), .rd_valid(rd_valid), .underflow(underflow),
    .level(level)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO memory, read synchronously at the DUT address.
  logic [7:0] mem [16];
  logic [7:0] data_q;
  always @(posedge clk) data_q <= mem[rd_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [4:0] rbin_m, wr_ptr_m, level_m;
  logic       empty_m, ae_m, valid_m, uf_m;
  logic [7:0] wr_seq;
  logic [7:0] exp_q[$];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard consumer: every rd_valid must deliver the next expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_valid: rd_valid=1 with no read outstanding");
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_q !== e) begin
          n_bad++;
          $display("FAIL sb_data: got %02h want %02h", data_q, e);
        end
      end
    end
  end

  task automatic model_reset();
    rbin_m = '0; wr_ptr_m = '0; level_m = '0;
    empty_m = 1'b1; ae_m = 1'b1; valid_m = 1'b0; uf_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; rd_en = 1'b0; wptr_gray_sync = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Publish writes up to wnew, drive rd_en, advance the model, clock once,
  // and return 1 ns after the edge.
  task automatic step(input logic rd, input logic [4:0] wnew);
    logic acc;
    while (wr_ptr_m != wnew) begin
      mem[wr_ptr_m[3:0]] = wr_seq;
      wr_seq = wr_seq + 8'd1;
      wr_ptr_m = wr_ptr_m + 5'd1;
    end
    rd_en = rd;
    wptr_gray_sync = gray(wnew);
    acc  = rd && !empty_m;
    uf_m = rd && empty_m;
    if (acc) begin
      exp_q.push_back(mem[rbin_m[3:0]]);
      rbin_m = rbin_m + 5'd1;
    end
    valid_m = acc;
    level_m = wnew - rbin_m;
    empty_m = (level_m == 5'd0);
    ae_m    = (level_m <= 5'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp += 7;
    if (empty !== 1'b1)        begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL rst_ae: got %b want 1", almost_empty); end
    if (level !== 5'd0)        begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
    if (rd_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    if (underflow !== 1'b0)    begin n_bad++; $display("FAIL rst_uf: got %b want 0", underflow); end
    if (rd_addr !== 4'd0)      begin n_bad++; $display("FAIL rst_addr: got %0d want 0", rd_addr); end
    if (rptr_gray !== 5'd0)    begin n_bad++; $display("FAIL rst_gray: got %b want 0", rptr_gray); end
  endtask

  task automatic test_underflow_empty();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd0);
      n_cmp += 4;
      if (empty !== 1'b1)     begin n_bad++; $display("FAIL uf_empty[%0d]: got %b want 1", i, empty); end
      if (rd_addr !== 4'd0)   begin n_bad++; $display("FAIL uf_addr[%0d]: got %0d want 0", i, rd_addr); end
      if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_pulse[%0d]: got %b want 1", i, underflow); end
      if (rd_valid !== 1'b0)  begin n_bad++; $display("FAIL uf_valid[%0d]: got %b want 0", i, rd_valid); end
    end
    step(1'b0, 5'd0);
    n_cmp++;
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_addr [3];
    reset_dut();
    step(1'b0, 5'd1);
    n_cmp += 3;
    if (empty !== 1'b0)        begin n_bad++; $display("FAIL basic_w1_empty: got %b want 0", empty); end
    if (level !== 5'd1)        begin n_bad++; $display("FAIL basic_w1_level: got %0d want 1", level); end
    if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL basic_w1_ae: got %b want 1", almost_empty); end
    step(1'b0, 5'd2);
    step(1'b0, 5'd3);
    n_cmp += 3;
    if (empty !== 1'b0)        begin n_bad++; $display("FAIL basic_w3_empty: got %b want 0", empty); end
    if (level !== 5'd3)        begin n_bad++; $display("FAIL basic_w3_level: got %0d want 3", level); end
    if (almost_empty !== 1'b0) begin n_bad++; $display("FAIL basic_w3_ae: got %b want 0", almost_empty); end
    exp_addr[0] = 4'd0; exp_addr[1] = 4'd1; exp_addr[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_addr !== exp_addr[i]) begin n_bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, rd_addr, exp_addr[i]); end
      step(1'b1, 5'd3);
      n_cmp += 2;
      if (rd_valid !== 1'b1)  begin n_bad++; $display("FAIL basic_valid[%0d]: got %b want 1", i, rd_valid); end
      if (level !== level_m)  begin n_bad++; $display("FAIL basic_level[%0d]: got %0d want %0d", i, level, level_m); end
    end
    n_cmp += 2;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_end_empty: got %b want 1", empty); end
    if (level !== 5'd0) begin n_bad++; $display("FAIL basic_end_level: got %0d want 0", level); end
    step(1'b0, 5'd3);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", rd_valid); end
  endtask

  task automatic test_full();
    reset_dut();
    step(1'b0, 5'd16);
    n_cmp += 3;
    if (level !== 5'd16)       begin n_bad++; $display("FAIL full_level: got %0d want 16", level); end
    if (empty !== 1'b0)        begin n_bad++; $display("FAIL full_empty: got %b want 0", empty); end
    if (almost_empty !== 1'b0) begin n_bad++; $display("FAIL full_ae: got %b want 0", almost_empty); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_addr !== 4'(i)) begin n_bad++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, rd_addr, i); end
      step(1'b1, 5'd16);
      n_cmp += 2;
      if (level !== level_m)        begin n_bad++; $display("FAIL full_lvl[%0d]: got %0d want %0d", i, level, level_m); end
      if (almost_empty !== ae_m)    begin n_bad++; $display("FAIL full_ae[%0d]: got %b want %b", i, almost_empty, ae_m); end
    end
    n_cmp += 2;
    if (rptr_gray !== 5'b11000) begin n_bad++; $display("FAIL full_gray_end: got %b want 11000", rptr_gray); end
    if (empty !== 1'b1)         begin n_bad++; $display("FAIL full_empty_end: got %b want 1", empty); end
    step(1'b1, 5'd16);
    n_cmp += 2;
    if (underflow !== 1'b1)     begin n_bad++; $display("FAIL full_uf: got %b want 1", underflow); end
    if (rptr_gray !== 5'b11000) begin n_bad++; $display("FAIL full_uf_hold: got %b want 11000", rptr_gray); end
  endtask

  task automatic test_wrap();
    logic [4:0] w;
    logic [4:0] prev;
    reset_dut();
    w = '0;
    for (int i = 0; i < 40; i++) begin
      prev = rptr_gray;
      w = w + 5'd1;
      step(1'b0, w);
      step(1'b1, w);
      n_cmp += 5;
      if ($countones(rptr_gray ^ prev) != 1) begin n_bad++; $display("FAIL wrap_gray_step[%0d]: got %b prev %b", i, rptr_gray, prev); end
      if (rptr_gray !== gray(rbin_m)) begin n_bad++; $display("FAIL wrap_gray[%0d]: got %b want %b", i, rptr_gray, gray(rbin_m)); end
      if (rd_addr !== rbin_m[3:0])    begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rd_addr, rbin_m[3:0]); end
      if (underflow !== 1'b0)         begin n_bad++; $display("FAIL wrap_uf[%0d]: got %b want 0", i, underflow); end
      if (empty !== empty_m)          begin n_bad++; $display("FAIL wrap_empty[%0d]: got %b want %b", i, empty, empty_m); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] w;
    reset_dut();
    w = 5'd1;
    step(1'b0, w);
    for (int i = 0; i < 6; i++) begin
      w = w + 5'd1;
      step(1'b1, w);
      n_cmp += 3;
      if (empty !== 1'b0)    begin n_bad++; $display("FAIL b2b_empty[%0d]: got %b want 0", i, empty); end
      if (level !== 5'd1)    begin n_bad++; $display("FAIL b2b_level[%0d]: got %0d want 1", i, level); end
      if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rd_valid); end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    step(1'b0, 5'd5);
    step(1'b1, 5'd5);
    step(1'b1, 5'd5);
    #2;
    rst_n = 1'b0;
    wptr_gray_sync = '0;
    rd_en = 1'b0;
    #1;
    n_cmp += 7;
    if (empty !== 1'b1)        begin n_bad++; $display("FAIL mrst_empty: got %b want 1", empty); end
    if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL mrst_ae: got %b want 1", almost_empty); end
    if (level !== 5'd0)        begin n_bad++; $display("FAIL mrst_level: got %0d want 0", level); end
    if (rd_valid !== 1'b0)     begin n_bad++; $display("FAIL mrst_valid: got %b want 0", rd_valid); end
    if (underflow !== 1'b0)    begin n_bad++; $display("FAIL mrst_uf: got %b want 0", underflow); end
    if (rd_addr !== 4'd0)      begin n_bad++; $display("FAIL mrst_addr: got %0d want 0", rd_addr); end
    if (rptr_gray !== 5'd0)    begin n_bad++; $display("FAIL mrst_gray: got %b want 0", rptr_gray); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 5'd2);
    step(1'b1, 5'd2);
    n_cmp += 3;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_resume_valid: got %b want 1", rd_valid); end
    if (level !== 5'd1)    begin n_bad++; $display("FAIL mrst_resume_level: got %0d want 1", level); end
    if (rd_addr !== 4'd1)  begin n_bad++; $display("FAIL mrst_resume_addr: got %0d want 1", rd_addr); end
  endtask

  initial begin
    wr_seq = 8'h30;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    test_reset();
    test_underflow_empty();
    test_basic();
    test_full();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    step(1'b0, 5'd2);
    step(1'b0, 5'd2);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width; FIFO depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter ALMOST_EMPTY_TH, default 1, level at or below which almost_empty asserts.
REQ-003 SHALL have port clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rd_en  input  1  read request from consumer.
REQ-006 SHALL have port wptr_gray_sync  input  ADDR_WIDTH+1  write pointer in Gray code, already passed through the team's two-flop synchronizer into clk domain.
REQ-007 SHALL have port rd_addr  output  ADDR_WIDTH  read address to FIFO memory.
REQ-008 SHALL have port rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, for synchronization into the write domain.
REQ-009 SHALL have port empty  output  1  registered empty flag.
REQ-010 SHALL have port almost_empty  output  1  registered; level <= ALMOST_EMPTY_TH.
REQ-011 SHALL have port rd_valid  output  1  memory data for the previously accepted read is valid this cycle.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse, read requested while empty.
REQ-013 SHALL have port level  output  ADDR_WIDTH+1  registered occupancy seen from read side, 0..2^ADDR_WIDTH.

Function
REQ-014 SHALL hold an internal binary read pointer rbin of ADDR_WIDTH+1 bits; rd_addr = rbin[ADDR_WIDTH-1:0] directly from the register.
REQ-015 SHALL accept a read when rd_en=1 and empty=0; accepted read increments rbin by 1 at the clock edge.
REQ-016 SHALL leave rbin, rptr_gray unchanged when rd_en=0 or empty=1.
REQ-017 SHALL register rptr_gray = rbin_next XOR (rbin_next >> 1), updated in the same edge as rbin; exactly one bit changes per accepted read.
REQ-018 SHALL wrap rbin from 2^(ADDR_WIDTH+1)-1 to 0 with no extra cycle; MSB toggles every 2^ADDR_WIDTH reads.
REQ-019 SHALL register empty = (Gray of rbin_next == wptr_gray_sync); empty deasserts no earlier than the cycle after wptr_gray_sync changes.
REQ-020 SHALL convert wptr_gray_sync to binary wbin (XOR-prefix from MSB) combinationally.
REQ-021 SHALL register level = (wbin - rbin_next) modulo 2^(ADDR_WIDTH+1).
REQ-022 SHALL register almost_empty = (level_next <= ALMOST_EMPTY_TH).
REQ-023 SHALL register rd_valid = 1 in the cycle after an accepted read, else 0; back-to-back reads give continuous rd_valid.
REQ-024 SHALL register underflow = 1 for one cycle after any edge with rd_en=1 and empty=1; no pointer change.
REQ-025 SHALL, when wptr_gray_sync changes in the same cycle as an accepted read, apply both: rbin increments and level/empty use the new wbin and rbin_next.
REQ-026 SHALL tolerate wptr_gray_sync lagging the true write pointer; empty is pessimistic (may stay 1 late), never falsely 0.

Reset
REQ-027 SHALL, on rst_n=0, immediately and asynchronously set rbin=0, rptr_gray=0, empty=1, almost_empty=1, level=0, rd_valid=0, underflow=0; rd_addr=0.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-read discards the in-flight rd_valid.
REQ-029 SHALL require the write side to be reset concurrently so wptr_gray_sync=0 at reset release.

Verification
REQ-030 Reset, wptr_gray_sync=0, rd_en=1 for 3 cycles -> empty=1, rd_addr=0, underflow pulses each cycle, rd_valid=0.
REQ-031 wptr_gray_sync steps 0->1->3->2 (wbin 3) -> empty=0, level=3, almost_empty=0; 3 reads -> rd_addr 0,1,2, rd_valid 3 cycles one cycle late, then empty=1, level=0.
REQ-032 Full FIFO: wbin=16, rbin=0 -> level=16; 16 consecutive reads -> rd_addr 0..15, rptr_gray ends 11000b, empty=1.
REQ-033 Wrap: 40 writes and 40 reads interleaved -> rbin passes 31->0, rptr_gray one-bit changes only, no false empty/underflow.
REQ-034 Read accepted in same cycle wptr_gray_sync advances by 1 with level=1 -> empty stays 0, level stays 1.
REQ-035 rst_n asserted mid-burst between edges -> all outputs reach reset values without a clock edge.
